// File: rtl/toast_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory and the arbiter.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface toast_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_valid;
    logic [DATA_WIDTH-1:0] if_rd_data;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wr_data;
    logic                  dm_gnt;
    logic                  dm_valid;
    logic [DATA_WIDTH-1:0] dm_rd_data;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wr_data, mem_rd_data,
        output if_gnt, if_valid, if_rd_data, dm_gnt, dm_valid, dm_rd_data,
               mem_addr, mem_wr_en, mem_wr_data
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wr_data, mem_rd_data,
        input  if_gnt, if_valid, if_rd_data, dm_gnt, dm_valid, dm_rd_data,
               mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/toast_mem_arbiter.sv
// Two-port (fetch/data) arbiter for a single-ported memory: data has priority,
// fetch is forced through after MAX_STARVE consecutive denials.
module toast_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STARVE = 4
) (
    input logic               Clk,
    input logic               Reset,
    toast_mem_arbiter_if.slave bus
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_STARVE);

    typedef enum logic {
        IDLE,
        RD_PEND
    } state_e;

    state_e                state_d, state_q;
    logic                  rd_src_d, rd_src_q;
    logic [3:0]            starve_cnt_d, starve_cnt_q;
    logic [ADDR_WIDTH-1:0] mem_addr_d, mem_addr_q;

    logic                  if_gnt, dm_gnt, rd_gnt, starve_hit;
    logic                  if_valid, dm_valid;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            rd_src_q     <= 1'b0;
            starve_cnt_q <= '0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            rd_src_q     <= rd_src_d;
            starve_cnt_q <= starve_cnt_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    always_comb begin
        state_d      = IDLE;
        rd_src_d     = rd_src_q;
        starve_cnt_d = '0;
        mem_addr_d   = mem_addr_q;

        // Grants are masked by the asynchronous reset so nothing leaks while it is held
        starve_hit = (starve_cnt_q == MAX_CNT);
        dm_gnt     = ~Reset & bus.dm_req & ~(bus.if_req & starve_hit);
        if_gnt     = ~Reset & bus.if_req & ~dm_gnt;
        rd_gnt     = if_gnt | (dm_gnt & ~bus.dm_we);

        if (rd_gnt) begin
            state_d  = RD_PEND;
            rd_src_d = dm_gnt;
        end

        if (bus.if_req && !if_gnt) begin
            starve_cnt_d = starve_hit ? starve_cnt_q : starve_cnt_q + 4'd1;
        end

        if (dm_gnt) begin
            mem_addr_d = bus.dm_addr;
        end else if (if_gnt) begin
            mem_addr_d = bus.if_addr;
        end

        if_valid = (state_q == RD_PEND) & ~rd_src_q;
        dm_valid = (state_q == RD_PEND) &  rd_src_q;
    end

    assign bus.if_gnt      = if_gnt;
    assign bus.dm_gnt      = dm_gnt;
    assign bus.if_valid    = if_valid;
    assign bus.dm_valid    = dm_valid;
    assign bus.if_rd_data  = if_valid ? bus.mem_rd_data : {DATA_WIDTH{1'b0}};
    assign bus.dm_rd_data  = dm_valid ? bus.mem_rd_data : {DATA_WIDTH{1'b0}};
    assign bus.mem_addr    = mem_addr_d;
    assign bus.mem_wr_en   = dm_gnt & bus.dm_we;
    assign bus.mem_wr_data = (dm_gnt & bus.dm_we) ? bus.dm_wr_data : {DATA_WIDTH{1'b0}};
endmodule

// File: doc/toast_mem_arbiter.md
TOAST_MEM_ARBITER -- requirements
Module: toast_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-003 SHALL have parameter MAX_STARVE, default 4, range 1-15, maximum consecutive fetch denials before fetch is forced.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Ports (name  direction  width  meaning):
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous active-high reset.
- if_req  in  1  fetch read request, held until granted.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  fetch request issued to memory this cycle.
- if_valid  out  1  fetch read data valid.
- if_rd_data  out  DATA_WIDTH  fetch read data.
- dm_req  in  1  data-stage request, held until granted.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wr_data  in  DATA_WIDTH  store data.
- dm_gnt  out  1  data request issued to memory this cycle.
- dm_valid  out  1  load data valid.
- dm_rd_data  out  DATA_WIDTH  load data.
- mem_addr  out  ADDR_WIDTH  shared memory address.
- mem_wr_en  out  1  shared memory write strobe.
- mem_wr_data  out  DATA_WIDTH  shared memory write data.
- mem_rd_data  in  DATA_WIDTH  memory read data, valid 1 cycle after the read is issued.

Function
REQ-006 Grant logic SHALL be combinational from the requests and registered state, with at most one of if_gnt and dm_gnt high per cycle.
REQ-007 Only dm_req SHALL give dm_gnt=1; only if_req SHALL give if_gnt=1.
REQ-008 Both requests with starve_cnt < MAX_STARVE SHALL give dm_gnt=1, if_gnt=0.
REQ-009 Both requests with starve_cnt == MAX_STARVE SHALL give if_gnt=1, dm_gnt=0.
REQ-010 starve_cnt SHALL be a 4-bit register: increments on cycles with if_req=1 and if_gnt=0, clears on if_gnt=1 or if_req=0, saturates at MAX_STARVE.
REQ-011 Issued request SHALL drive the mem_* outputs combinationally in the grant cycle.
- mem_addr = the granted address.
- mem_wr_en = dm_gnt & dm_we.
- mem_wr_data = dm_wr_data.
REQ-012 Without a grant, mem_wr_en SHALL be 0 and mem_addr SHALL hold its previous registered value.
REQ-013 SHALL keep a 2-state read-tracking FSM.
- IDLE: no read outstanding.
- RD_PEND: read issued last cycle; the registered source bit rd_src (0 = fetch, 1 = data) identifies the requester.
REQ-014 FSM transitions:
- Any read grant: -> RD_PEND, capturing the source.
- Write grant or no grant: -> IDLE.
- RD_PEND accepts a new grant in the same cycle (back-to-back, one read per cycle throughput).
REQ-015 In RD_PEND, the valid for rd_src SHALL be 1 for exactly one cycle; that requester's rd_data = mem_rd_data (combinational pass-through).
REQ-016 if_valid and dm_valid SHALL never be high together; rd_data outputs are don't-care when not valid.
REQ-017 A write SHALL complete in its grant cycle and produce no dm_valid.
REQ-018 Requesters SHALL keep addr, data and we stable while req=1 and gnt=0; the arbiter does not latch ungranted requests.

Reset
REQ-019 While Reset=1, outputs SHALL be:
- if_gnt = dm_gnt = if_valid = dm_valid = mem_wr_en = 0.
- mem_addr = 0.
- FSM in IDLE, starve_cnt = 0.
REQ-020 Reset during RD_PEND SHALL discard the outstanding read: no valid after release.
REQ-021 The first grant after reset SHALL be possible in the first cycle with Reset=0.

Verification
REQ-022 Fetch only:
- Stimulus: if_req=1 with if_addr 0x0, 0x4, 0x8 on consecutive cycles; memory returns 0xA0000000 + addr.
- Response: if_gnt=1 every cycle; if_valid one cycle later with 0xA0000000, 0xA0000004, 0xA0000008.
REQ-023 Simultaneous read:
- Stimulus: if_req=1 addr 0x10 and dm_req=1 dm_we=0 addr 0x100 in the same cycle.
- Response: dm_gnt first, then dm_valid; if_gnt the next cycle; if_valid the cycle after.
REQ-024 Store:
- Stimulus: dm_req=1 dm_we=1 addr 0x40 data 0xDEADBEEF.
- Response: mem_wr_en=1, mem_addr=0x40, mem_wr_data=0xDEADBEEF for one cycle; no dm_valid.
REQ-025 Starvation, MAX_STARVE=4:
- Stimulus: dm_req and if_req held high continuously.
- Response: 4 dm grants, 1 if grant, repeating.
REQ-026 Reset mid-read:
- Stimulus: assert Reset in the cycle after a read grant.
- Response: no if_valid or dm_valid; all outputs 0.
REQ-027 Idle:
- Stimulus: no requests for 5 cycles.
- Response: mem_wr_en=0 and no grants or valids.
